// File: rtl/flags_register_if.sv
// Microcode-side bundle for the 8086 FLAGS register: write sources, boundary
// events and the architectural flags/interrupt/trap status returned to the core.
interface flags_register_if;
  logic        alu_update;
  logic [15:0] alu_flags;
  logic [15:0] alu_mask;
  logic        load_valid;
  logic        load_low_only;
  logic [15:0] load_data;
  logic        flag_op_valid;
  logic [2:0]  flag_op;
  logic        inhibit_next;
  logic        instr_done;
  logic        trap_ack;
  logic [15:0] flags;
  logic        irq_allowed;
  logic        trap_req;

  modport master (
    output alu_update, alu_flags, alu_mask,
    output load_valid, load_low_only, load_data,
    output flag_op_valid, flag_op,
    output inhibit_next, instr_done, trap_ack,
    input  flags, irq_allowed, trap_req
  );

  modport slave (
    input  alu_update, alu_flags, alu_mask,
    input  load_valid, load_low_only, load_data,
    input  flag_op_valid, flag_op,
    input  inhibit_next, instr_done, trap_ack,
    output flags, irq_allowed, trap_req
  );
endinterface

// File: rtl/flags_register.sv
// 8086 FLAGS register: prioritised load / flag-op / ALU merge, STI and MOV SS
// interrupt shadow, and single-step trap request generation.
module flags_register #(
  parameter logic [15:0] RESET_FLAGS = 16'hF002
) (
  input logic        clk,
  input logic        reset_n,
  flags_register_if.slave bus
);
  localparam logic [15:0] FIXED_ONES = 16'hF002;
  localparam logic [15:0] WRITABLE   = 16'h0FD5;
  localparam logic [15:0] ARITH      = 16'h08D5;
  localparam logic [15:0] LOW_BYTE   = 16'h00D5;
  localparam int CF = 0;
  localparam int TF = 8;
  localparam int IF = 9;
  localparam int DF = 10;

  typedef enum logic [2:0] {
    OP_CLC, OP_STC, OP_CMC, OP_CLI, OP_STI, OP_CLD, OP_STD, OP_INTENTRY
  } flag_op_e;

  logic [15:0] flags_reg;
  logic [15:0] flags_next;
  logic [15:0] alu_merged;
  logic [1:0]  shadow_cnt_reg;
  logic        tf_armed_reg;
  logic        trap_req_reg;
  logic        sti_open;

  // Only the arithmetic flags are reachable from the ALU; TF/IF/DF stay put.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_alu_merge
      assign alu_merged[gi] = (ARITH[gi] && bus.alu_mask[gi]) ? bus.alu_flags[gi]
                                                              : flags_reg[gi];
    end
  endgenerate

  always_comb begin
    flags_next = flags_reg;
    sti_open   = 1'b0;
    if (bus.load_valid) begin
      if (bus.load_low_only)
        flags_next = (flags_reg & ~LOW_BYTE) | (bus.load_data & LOW_BYTE);
      else
        flags_next = (flags_reg & ~WRITABLE) | (bus.load_data & WRITABLE);
    end else if (bus.flag_op_valid) begin
      case (flag_op_e'(bus.flag_op))
        OP_CLC:      flags_next[CF] = 1'b0;
        OP_STC:      flags_next[CF] = 1'b1;
        OP_CMC:      flags_next[CF] = ~flags_reg[CF];
        OP_CLI:      flags_next[IF] = 1'b0;
        OP_STI: begin
          flags_next[IF] = 1'b1;
          // Only an IF 0->1 transition opens the one-instruction shadow.
          sti_open       = ~flags_reg[IF];
        end
        OP_CLD:      flags_next[DF] = 1'b0;
        OP_STD:      flags_next[DF] = 1'b1;
        OP_INTENTRY: begin
          flags_next[TF] = 1'b0;
          flags_next[IF] = 1'b0;
        end
        default:     flags_next = flags_reg;
      endcase
    end else if (bus.alu_update) begin
      flags_next = alu_merged;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_reg      <= (RESET_FLAGS & WRITABLE) | FIXED_ONES;
      shadow_cnt_reg <= 2'd0;
      tf_armed_reg   <= 1'b0;
      trap_req_reg   <= 1'b0;
    end else begin
      flags_reg <= (flags_next & WRITABLE) | FIXED_ONES;

      if (bus.inhibit_next || sti_open)
        shadow_cnt_reg <= 2'd2;
      else if (bus.instr_done && (shadow_cnt_reg != 2'd0))
        shadow_cnt_reg <= shadow_cnt_reg - 2'd1;

      // TF is sampled at the boundary, so a POPF setting TF traps one instruction later.
      if (bus.instr_done)
        tf_armed_reg <= flags_reg[TF];

      if (bus.instr_done && tf_armed_reg && (shadow_cnt_reg == 2'd0))
        trap_req_reg <= 1'b1;
      else if (bus.trap_ack)
        trap_req_reg <= 1'b0;
    end
  end

  assign bus.flags       = flags_reg;
  assign bus.irq_allowed = flags_reg[IF] & (shadow_cnt_reg == 2'd0);
  assign bus.trap_req    = trap_req_reg;
endmodule
